output_port_allocator: RTL

- Per-output-port allocator for the NoC router. One instance sits in front of each output port of the crossbar.
- Arbitrates between input ports whose head flit targets this output, using least-recently-granted matrix priority.
- Holds the grant for the whole wormhole packet, until the tail flit is sent.
- Gates every flit transfer on a downstream credit counter.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/rr_matrix_arbiter.sv | 55 +++++
 rtl/output_port_allocator.sv | 106 ++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions.
//   NUM_PORTS / PORT_* : router port count and port index constants
//   CREDIT_MAX_DEF     : default downstream buffer depth in flits
//   flit_type_e        : flit kind carried alongside each flit
//   alloc_state_e      : output allocator FSM states
//   clog2()            : ceiling log2 helper for index widths
package noc_pkg;
  localparam int NUM_PORTS      = 5;
  localparam int PORT_N         = 0;
  localparam int PORT_E         = 1;
  localparam int PORT_S         = 2;
  localparam int PORT_W         = 3;
  localparam int PORT_L         = 4;
  localparam int CREDIT_MAX_DEF = 4;

  typedef enum logic [1:0] {
    FLIT_HEAD,
    FLIT_BODY,
    FLIT_TAIL,
    FLIT_HEADTAIL
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } alloc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_matrix_arbiter.sv
// Least-recently-granted matrix arbiter.
//   clk, rst : clock, async active-high reset
//   req[N]   : requesting inputs
//   update   : pulse; the current winner drops to lowest priority
//   win[N]   : one-hot winner among req (0 when req==0)
// Only the upper triangle of the priority matrix is stored: bit (a,b), a<b,
// set means a beats b. Reset clears all bits so higher indices win.
module rr_matrix_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] win
);
  localparam int NP = N * (N - 1) / 2;

  function automatic int pidx(input int a, input int b);
    return a * N - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

  logic [NP-1:0]         pri;
  logic [N-1:0][N-1:0]   bt;   // bt[a][b]: a beats b

  always_comb begin
    bt = '0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        bt[a][b] = pri[pidx(a, b)];
        bt[b][a] = ~pri[pidx(a, b)];
      end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      win[i] = req[i];
      for (int j = 0; j < N; j++)
        if (j != i && req[j] && bt[j][i]) win[i] = 1'b0;
    end
  end

  // Winner loses to everyone else; pairs not involving it are untouched.
  for (genvar a = 0; a < N; a++) begin : g_row
    for (genvar b = a + 1; b < N; b++) begin : g_col
      localparam int K = pidx(a, b);
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  pri[K] <= 1'b0;
        else if (update && win[a]) pri[K] <= 1'b0;
        else if (update && win[b]) pri[K] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole allocator with credit-based flow control.
//   clk, rst      : clock, async active-high reset
//   req/head/tail : per-input flit valid, head and tail flags for this output
//   credit_return : downstream freed one slot
//   gnt, sel      : one-hot grant and its binary index (zero-cycle, comb)
//   fire          : a flit crosses this cycle
//   locked        : a packet owns the output
//   credits       : current downstream credit count
//   err_ovf       : sticky credit overflow flag
module output_port_allocator
  import noc_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CREDIT_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN-1:0]          req,
  input  logic [NUM_IN-1:0]          head,
  input  logic [NUM_IN-1:0]          tail,
  input  logic                       credit_return,
  output logic [NUM_IN-1:0]          gnt,
  output logic [$clog2(NUM_IN)-1:0]  sel,
  output logic                       fire,
  output logic                       locked,
  output logic [CREDIT_W-1:0]        credits,
  output logic                       err_ovf
);
  localparam int SEL_W = clog2(NUM_IN);
  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);

  alloc_state_e      state, state_nx;
  logic [SEL_W-1:0]  owner, owner_nx;
  logic [NUM_IN-1:0] eligible, win;
  logic              has_cred;

  assign has_cred = (credits != '0);
  assign eligible = (state == ST_IDLE) ? (req & head) : '0;

  // Matrix moves only on granted head flits, i.e. fires out of IDLE.
  rr_matrix_arbiter #(.N(NUM_IN)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (eligible),
    .update ((state == ST_IDLE) && fire),
    .win    (win)
  );

  always_comb begin
    gnt = '0;
    if (has_cred) begin
      if (state == ST_IDLE) gnt = win;
      else                  gnt[owner] = req[owner];
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (gnt[i]) sel = SEL_W'(i);
  end

  assign fire   = |gnt;
  assign locked = (state == ST_LOCKED);

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      ST_IDLE: begin
        if (fire && !(|(gnt & tail))) begin
          state_nx = ST_LOCKED;
          owner_nx = sel;
        end
      end
      ST_LOCKED: begin
        if (fire && tail[owner]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // fire is never asserted at zero credits, so no underflow guard needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CMAX;
      err_ovf <= 1'b0;
    end else if (fire && !credit_return) begin
      credits <= credits - 1'b1;
    end else if (!fire && credit_return) begin
      if (credits == CMAX) err_ovf <= 1'b1;
      else                 credits <= credits + 1'b1;
    end
  end
endmodule
